axi_stream_sync_fifo: RTL

- Single-clock AXI4-Stream FIFO. It buffers a full beat (TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER) between an upstream producer and a downstream consumer.
- The master side is built to satisfy the team's AXI-Stream master property set: stable payload while stalled, TVALID low in reset, TSTRB only where TKEEP is set.
- It is the buffering stage placed directly ahead of any interface checked by that property set.

---
 rtl/axi_stream_sync_fifo.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/axi_stream_sync_fifo.sv
// axi_stream_sync_fifo: single-clock AXI4-Stream FIFO carrying a complete beat
// (TDATA, TSTRB, TKEEP, TLAST, TID, TDEST, TUSER) from slave to master side.
// The head beat lives in a dedicated output register. Because of that, every
// master-side output is a flop, and the payload holds still while stalled.
// Optional build macro: AXIS_FIFO_PACKET_MODE_EN. When it is defined, the
// master side only presents beats once a complete packet is stored. A release
// mode also drains a full FIFO that holds no packet end.
module axi_stream_sync_fifo #(
  parameter int byte_width = 4,
  parameter int id_width   = 1,
  parameter int dest_width = 1,
  parameter int user_width = 1,
  parameter int depth_log2 = 4
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    s_tvalid,
  output logic                    s_tready,
  input  logic [8*byte_width-1:0] s_tdata,
  input  logic [byte_width-1:0]   s_tstrb,
  input  logic [byte_width-1:0]   s_tkeep,
  input  logic                    s_tlast,
  input  logic [id_width-1:0]     s_tid,
  input  logic [dest_width-1:0]   s_tdest,
  input  logic [user_width-1:0]   s_tuser,
  output logic                    m_tvalid,
  input  logic                    m_tready,
  output logic [8*byte_width-1:0] m_tdata,
  output logic [byte_width-1:0]   m_tstrb,
  output logic [byte_width-1:0]   m_tkeep,
  output logic                    m_tlast,
  output logic [id_width-1:0]     m_tid,
  output logic [dest_width-1:0]   m_tdest,
  output logic [user_width-1:0]   m_tuser,
  output logic [depth_log2:0]     level
);

  localparam int Depth = 1 << depth_log2;
  localparam int LvlW  = depth_log2 + 1;
  localparam int BeatW = 8*byte_width + 2*byte_width + 1 + id_width + dest_width + user_width;
  localparam logic [LvlW-1:0] Full = {1'b1, {depth_log2{1'b0}}};
  localparam logic [LvlW-1:0] Empty = {LvlW{1'b0}};

  logic [BeatW-1:0]      mem_q [Depth];
  logic [depth_log2-1:0] wr_ptr_q, wr_ptr_d;
  logic [depth_log2-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]       level_q, level_d;
  logic [BeatW-1:0]      out_q, out_d;
  logic                  s_tready_q, s_tready_d;
  logic                  m_tvalid_q, m_tvalid_d;
  logic [BeatW-1:0]      in_beat_s;
  logic                  push_s, pop_s;
`ifdef AXIS_FIFO_PACKET_MODE_EN
  logic [LvlW-1:0]       pkt_q, pkt_d;
  logic                  rel_q, rel_d;
`endif

  // Strobes are masked with keep on entry so the master never shows strb without keep.
  assign in_beat_s = {s_tdata, s_tstrb & s_tkeep, s_tkeep, s_tlast, s_tid, s_tdest, s_tuser};
  assign {m_tdata, m_tstrb, m_tkeep, m_tlast, m_tid, m_tdest, m_tuser} = out_q;
  assign push_s   = s_tvalid && s_tready_q;
  assign pop_s    = m_tvalid_q && m_tready;
  assign s_tready = s_tready_q;
  assign m_tvalid = m_tvalid_q;
  assign level    = level_q;

  // Next-state for pointers, occupancy, head register and handshake flags.
  always_comb begin
    wr_ptr_d = push_s ? (wr_ptr_q + depth_log2'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + depth_log2'(1)) : rd_ptr_q;

    case ({push_s, pop_s})
      2'b10:   level_d = level_q + LvlW'(1);
      2'b01:   level_d = level_q - LvlW'(1);
      default: level_d = level_q;
    endcase

    // The head is reloaded only when it is consumed or when the FIFO was empty.
    // A beat being written into the new head slot bypasses the memory.
    out_d = out_q;
    if (pop_s || (level_q == Empty)) begin
      if (push_s && (rd_ptr_d == wr_ptr_q)) begin
        out_d = in_beat_s;
      end else if (level_d != Empty) begin
        out_d = mem_q[rd_ptr_d];
      end else begin
        out_d = out_q;
      end
    end else begin
      out_d = out_q;
    end

    s_tready_d = (level_d != Full);

`ifdef AXIS_FIFO_PACKET_MODE_EN
    case ({push_s && s_tlast, pop_s && m_tlast})
      2'b10:   pkt_d = pkt_q + LvlW'(1);
      2'b01:   pkt_d = pkt_q - LvlW'(1);
      default: pkt_d = pkt_q;
    endcase
    // A full FIFO that holds no packet end would deadlock. In that case, drain
    // it cut-through until a beat with TLAST leaves.
    rel_d = (rel_q && !(pop_s && m_tlast)) || ((level_d == Full) && (pkt_d == Empty));
    m_tvalid_d = (level_d != Empty) && ((pkt_d != Empty) || rel_d);
`else
    m_tvalid_d = (level_d != Empty);
`endif
  end

  // Beat storage; contents need no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= in_beat_s;
    end
  end

  // Control and output registers, cleared immediately on reset assertion.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr_q   <= {depth_log2{1'b0}};
      rd_ptr_q   <= {depth_log2{1'b0}};
      level_q    <= Empty;
      out_q      <= {BeatW{1'b0}};
      s_tready_q <= 1'b0;
      m_tvalid_q <= 1'b0;
`ifdef AXIS_FIFO_PACKET_MODE_EN
      pkt_q      <= Empty;
      rel_q      <= 1'b0;
`endif
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      out_q      <= out_d;
      s_tready_q <= s_tready_d;
      m_tvalid_q <= m_tvalid_d;
`ifdef AXIS_FIFO_PACKET_MODE_EN
      pkt_q      <= pkt_d;
      rel_q      <= rel_d;
`endif
    end
  end

endmodule
